// File: rtl/wbupsize_pkg.sv
// rtl/wbupsize_pkg.sv - shared helpers for the wbupsize bus upsizer
//
// Purpose: width derivation helpers and the lane placement function shared by
// the upsizer top and its sub-address FIFO.
// Configuration macro: WBUPSIZE_LITTLE_ENDIAN_EN selects little-endian lane
// placement (lane k at the low end); undefined gives big-endian placement
// (lane 0 at the most significant end).
// Ports: none (package).

package wbupsize_pkg;

    // Sub-address width for a given narrow/wide data width pair.
    function automatic int calc_lgratio(input int dwin, input int dwout);
        return $clog2(dwout / dwin);
    endfunction

    // Wide-side word address width: the sub-address bits are dropped.
    function automatic int calc_awout(input int awin, input int dwin, input int dwout);
        return awin - calc_lgratio(dwin, dwout);
    endfunction

    // Returns the slot index, counted from bit 0 of the wide word, that
    // sub-address k occupies. Multiply by the narrow width for a bit offset.
    function automatic int lane_shift(input int k, input int lgratio);
`ifdef WBUPSIZE_LITTLE_ENDIAN_EN
        return k + (lgratio * 0);
`else
        return (1 << lgratio) - 1 - k;
`endif
    endfunction

endpackage

// File: rtl/wbupsize_fifo.sv
// rtl/wbupsize_fifo.sv - synchronous FIFO of outstanding request sub-addresses
//
// Purpose: remembers the lane of every request in flight so the returning
// wide word can be narrowed to the correct lane, in request order.
// Ports:
//   i_clk, i_reset   clock, synchronous active-high reset
//   push_i           write push_data_i (ignored when full)
//   push_data_i      W-bit sub-address
//   pop_i            discard head entry (ignored when empty)
//   flush_i          empty the FIFO; wins over push and pop
//   head_o           oldest entry
//   count_o          number of entries, 0..2^LGFIFO
//   full_o, empty_o  occupancy flags

module wbupsize_fifo
    import wbupsize_pkg::*;
#(
    parameter int LGFIFO = 5,
    parameter int W      = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              push_i,
    input  logic [W-1:0]      push_data_i,
    input  logic              pop_i,
    input  logic              flush_i,
    output logic [W-1:0]      head_o,
    output logic [LGFIFO:0]   count_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int DEPTH = 1 << LGFIFO;

    logic [W-1:0]        mem_q [DEPTH];
    logic [LGFIFO-1:0]   wr_ptr_q, wr_ptr_d;
    logic [LGFIFO-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LGFIFO:0]     count_q, count_d;
    logic                do_push, do_pop;

    assign full_o  = (count_q == (LGFIFO+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers are exactly LGFIFO bits wide so they wrap on their own.
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/wbupsize.sv
// rtl/wbupsize.sv - pipelined Wishbone upsizer, narrow slave to wide master
//
// Purpose: places each narrow request on its lane of the wide bus, keeps a
// FIFO of in-flight sub-addresses and narrows the returned data accordingly.
// Configuration macro: WBUPSIZE_LITTLE_ENDIAN_EN (see wbupsize_pkg).
// Ports:
//   i_clk, i_reset                          clock, synchronous active-high reset
//   i_s_cyc/stb/we/addr/data/sel            narrow slave request
//   o_s_ack, o_s_err, o_s_stall, o_s_data   narrow slave response
//   o_m_cyc/stb/we/addr/data/sel            wide master request
//   i_m_ack, i_m_err, i_m_stall, i_m_data   wide master response

module wbupsize
    import wbupsize_pkg::*;
#(
    parameter int AWIN   = 30,
    parameter int DWIN   = 32,
    parameter int DWOUT  = 128,
    parameter int LGFIFO = 5,
    localparam int LGRATIO = calc_lgratio(DWIN, DWOUT),
    localparam int AWOUT   = calc_awout(AWIN, DWIN, DWOUT)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_s_cyc,
    input  logic                 i_s_stb,
    input  logic                 i_s_we,
    input  logic [AWIN-1:0]      i_s_addr,
    input  logic [DWIN-1:0]      i_s_data,
    input  logic [DWIN/8-1:0]    i_s_sel,
    output logic                 o_s_ack,
    output logic                 o_s_err,
    output logic                 o_s_stall,
    output logic [DWIN-1:0]      o_s_data,
    output logic                 o_m_cyc,
    output logic                 o_m_stb,
    output logic                 o_m_we,
    output logic [AWOUT-1:0]     o_m_addr,
    output logic [DWOUT-1:0]     o_m_data,
    output logic [DWOUT/8-1:0]   o_m_sel,
    input  logic                 i_m_ack,
    input  logic                 i_m_err,
    input  logic                 i_m_stall,
    input  logic [DWOUT-1:0]     i_m_data
);

    // FIFO entries need at least one bit even when the ratio is 1.
    localparam int SW   = (LGRATIO > 0) ? LGRATIO : 1;
    localparam int SELI = DWIN / 8;
    localparam int SELO = DWOUT / 8;

    // Master request stage
    logic                m_cyc_q, m_cyc_d;
    logic                m_stb_q, m_stb_d;
    logic                m_we_q, m_we_d;
    logic [AWOUT-1:0]    m_addr_q, m_addr_d;
    logic [DWOUT-1:0]    m_data_q, m_data_d;
    logic [SELO-1:0]     m_sel_q, m_sel_d;

    // One-entry skid buffer holding a full narrow request
    logic                skid_valid_q, skid_valid_d;
    logic                skid_we_q, skid_we_d;
    logic [AWIN-1:0]     skid_addr_q, skid_addr_d;
    logic [DWIN-1:0]     skid_data_q, skid_data_d;
    logic [SELI-1:0]     skid_sel_q, skid_sel_d;

    // Slave response stage
    logic                s_ack_q, s_ack_d;
    logic                s_err_q, s_err_d;
    logic [DWIN-1:0]     s_data_q, s_data_d;

    // Request source: the skid entry always goes before new input
    logic                src_we;
    logic [AWIN-1:0]     src_addr;
    logic [DWIN-1:0]     src_data;
    logic [SELI-1:0]     src_sel;
    logic [SW-1:0]       src_k;
    logic [SW-1:0]       s_k;
    logic [DWOUT-1:0]    src_wdata;
    logic [SELO-1:0]     src_wsel;
    int                  src_lane;
    int                  head_lane;

    logic                accept;
    logic                master_free;
    logic                m_err;
    logic                kill;

    logic [SW-1:0]       fifo_head;
    logic [LGFIFO:0]     fifo_count;
    logic                fifo_full;
    logic                fifo_empty;

    generate
        if (LGRATIO > 0) begin : g_sub
            assign s_k   = i_s_addr[LGRATIO-1:0];
            assign src_k = src_addr[LGRATIO-1:0];
        end else begin : g_nosub
            assign s_k   = '0;
            assign src_k = '0;
        end
    endgenerate

    assign o_s_stall   = skid_valid_q || fifo_full;
    assign accept      = i_s_cyc && i_s_stb && !o_s_stall;
    assign master_free = !m_stb_q || !i_m_stall;
    assign m_err       = i_m_err && m_cyc_q;
    // Either a bus error or the CPU dropping cyc abandons everything in flight.
    assign kill        = m_err || !i_s_cyc;

    assign src_we   = skid_valid_q ? skid_we_q   : i_s_we;
    assign src_addr = skid_valid_q ? skid_addr_q : i_s_addr;
    assign src_data = skid_valid_q ? skid_data_q : i_s_data;
    assign src_sel  = skid_valid_q ? skid_sel_q  : i_s_sel;

    always_comb begin
        src_lane  = lane_shift(int'(src_k), LGRATIO);
        src_wdata = DWOUT'(src_data) << (src_lane * DWIN);
        src_wsel  = SELO'(src_sel) << (src_lane * SELI);
        head_lane = lane_shift(int'(fifo_head), LGRATIO);
    end

    wbupsize_fifo #(
        .LGFIFO (LGFIFO),
        .W      (SW)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .push_i      (accept),
        .push_data_i (s_k),
        .pop_i       (i_m_ack),
        .flush_i     (kill),
        .head_o      (fifo_head),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_comb begin
        m_stb_d      = m_stb_q;
        m_we_d       = m_we_q;
        m_addr_d     = m_addr_q;
        m_data_d     = m_data_q;
        m_sel_d      = m_sel_q;
        skid_valid_d = skid_valid_q;
        skid_we_d    = skid_we_q;
        skid_addr_d  = skid_addr_q;
        skid_data_d  = skid_data_q;
        skid_sel_d   = skid_sel_q;
        s_data_d     = s_data_q;

        if (master_free) begin
            // A valid skid entry stalls the slave, so it never competes with
            // a fresh acceptance in the same cycle.
            if (skid_valid_q || accept) begin
                m_stb_d      = 1'b1;
                m_we_d       = src_we;
                m_addr_d     = src_addr[AWIN-1:LGRATIO];
                m_data_d     = src_wdata;
                m_sel_d      = src_wsel;
                skid_valid_d = 1'b0;
            end else begin
                m_stb_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_we_d    = i_s_we;
            skid_addr_d  = i_s_addr;
            skid_data_d  = i_s_data;
            skid_sel_d   = i_s_sel;
        end

        if (kill) begin
            m_stb_d      = 1'b0;
            skid_valid_d = 1'b0;
        end

        m_cyc_d = i_s_cyc && !m_err;

        // Acks with nothing outstanding are strays and are dropped.
        s_ack_d = i_m_ack && !fifo_empty && !kill;
        s_err_d = m_err && i_s_cyc;
        if (s_ack_d) s_data_d = DWIN'(i_m_data >> (head_lane * DWIN));
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            m_cyc_q      <= 1'b0;
            m_stb_q      <= 1'b0;
            skid_valid_q <= 1'b0;
            s_ack_q      <= 1'b0;
            s_err_q      <= 1'b0;
        end else begin
            m_cyc_q      <= m_cyc_d;
            m_stb_q      <= m_stb_d;
            skid_valid_q <= skid_valid_d;
            s_ack_q      <= s_ack_d;
            s_err_q      <= s_err_d;
        end
    end

    always_ff @(posedge i_clk) begin
        m_we_q      <= m_we_d;
        m_addr_q    <= m_addr_d;
        m_data_q    <= m_data_d;
        m_sel_q     <= m_sel_d;
        skid_we_q   <= skid_we_d;
        skid_addr_q <= skid_addr_d;
        skid_data_q <= skid_data_d;
        skid_sel_q  <= skid_sel_d;
        s_data_q    <= s_data_d;
    end

    assign o_m_cyc  = m_cyc_q;
    assign o_m_stb  = m_stb_q;
    assign o_m_we   = m_we_q;
    assign o_m_addr = m_addr_q;
    assign o_m_data = m_data_q;
    assign o_m_sel  = m_sel_q;
    assign o_s_ack  = s_ack_q;
    assign o_s_err  = s_err_q;
    assign o_s_data = s_data_q;

endmodule

// File: tb/tb_wbupsize.sv
// tb/tb_wbupsize.sv - scoreboard bench for wbupsize (32->128 LGFIFO=2, 32->64)

module tb_wbupsize;

    logic i_clk = 1'b0;
    always #5 i_clk = ~i_clk;
    logic i_reset;

    localparam logic [127:0] MEM_A = 128'h11111111_22222222_33333333_44444444;
    localparam logic [63:0]  MEM_B = 64'hAAAA5555_12345678;

    // DUT A: 32 -> 128, LGFIFO = 2
    logic         a_s_cyc, a_s_stb, a_s_we;
    logic [29:0]  a_s_addr;
    logic [31:0]  a_s_data;
    logic [3:0]   a_s_sel;
    logic         a_s_ack, a_s_err, a_s_stall;
    logic [31:0]  a_s_rdata;
    logic         a_m_cyc, a_m_stb, a_m_we;
    logic [27:0]  a_m_addr;
    logic [127:0] a_m_data;
    logic [15:0]  a_m_sel;
    logic         a_m_ack, a_m_err, a_m_stall;
    logic [127:0] a_m_rdata;

    // DUT B: 32 -> 64, LGFIFO = 5
    logic         b_s_cyc, b_s_stb, b_s_we;
    logic [29:0]  b_s_addr;
    logic [31:0]  b_s_data;
    logic [3:0]   b_s_sel;
    logic         b_s_ack, b_s_err, b_s_stall;
    logic [31:0]  b_s_rdata;
    logic         b_m_cyc, b_m_stb, b_m_we;
    logic [28:0]  b_m_addr;
    logic [63:0]  b_m_data;
    logic [7:0]   b_m_sel;
    logic         b_m_ack, b_m_err, b_m_stall;
    logic [63:0]  b_m_rdata;

    wbupsize #(.AWIN(30), .DWIN(32), .DWOUT(128), .LGFIFO(2)) u_dut_a (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_s_cyc(a_s_cyc), .i_s_stb(a_s_stb), .i_s_we(a_s_we),
        .i_s_addr(a_s_addr), .i_s_data(a_s_data), .i_s_sel(a_s_sel),
        .o_s_ack(a_s_ack), .o_s_err(a_s_err), .o_s_stall(a_s_stall), .o_s_data(a_s_rdata),
        .o_m_cyc(a_m_cyc), .o_m_stb(a_m_stb), .o_m_we(a_m_we),
        .o_m_addr(a_m_addr), .o_m_data(a_m_data), .o_m_sel(a_m_sel),
        .i_m_ack(a_m_ack), .i_m_err(a_m_err), .i_m_stall(a_m_stall), .i_m_data(a_m_rdata)
    );

    wbupsize #(.AWIN(30), .DWIN(32), .DWOUT(64), .LGFIFO(5)) u_dut_b (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_s_cyc(b_s_cyc), .i_s_stb(b_s_stb), .i_s_we(b_s_we),
        .i_s_addr(b_s_addr), .i_s_data(b_s_data), .i_s_sel(b_s_sel),
        .o_s_ack(b_s_ack), .o_s_err(b_s_err), .o_s_stall(b_s_stall), .o_s_data(b_s_rdata),
        .o_m_cyc(b_m_cyc), .o_m_stb(b_m_stb), .o_m_we(b_m_we),
        .o_m_addr(b_m_addr), .o_m_data(b_m_data), .o_m_sel(b_m_sel),
        .i_m_ack(b_m_ack), .i_m_err(b_m_err), .i_m_stall(b_m_stall), .i_m_data(b_m_rdata)
    );

    typedef struct packed {
        logic         we;
        logic [27:0]  addr;
        logic [127:0] data;
        logic [15:0]  sel;
    } areq_t;

    typedef struct packed {
        logic         we;
        logic [28:0]  addr;
        logic [63:0]  data;
        logic [7:0]   sel;
    } breq_t;

    areq_t        a_mq[$];
    logic [31:0]  a_sq[$];
    breq_t        b_mq[$];
    logic [31:0]  b_sq[$];

    int total = 0;
    int bad   = 0;

    logic       ack_auto;
    logic [1:0] ack_pipe;
    int         stall_cnt;

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic areq_t mka(input logic we, input logic [27:0] addr,
                                  input logic [127:0] data, input logic [15:0] sel);
        areq_t r;
        r.we = we; r.addr = addr; r.data = data; r.sel = sel;
        return r;
    endfunction

    function automatic breq_t mkb(input logic we, input logic [28:0] addr,
                                  input logic [63:0] data, input logic [7:0] sel);
        breq_t r;
        r.we = we; r.addr = addr; r.data = data; r.sel = sel;
        return r;
    endfunction

    // One clock; inputs change 1 time unit after the rising edge. Also runs
    // the A-side memory responder (2-cycle ack) and the stall countdown.
    task automatic step();
        logic acc;
        acc = (a_m_stb === 1'b1) && (a_m_stall === 1'b0);
        @(posedge i_clk);
        #1;
        ack_pipe = {ack_pipe[0], acc};
        if (ack_auto) a_m_ack = ack_pipe[1];
        if (stall_cnt > 0) stall_cnt--;
        a_m_stall = (stall_cnt > 0);
    endtask

    task automatic issue(input logic we, input logic [29:0] addr, input logic [31:0] data,
                         input logic [3:0] sel, input logic push_m, input areq_t exp_m,
                         input logic push_s, input logic [31:0] exp_s);
        logic acc;
        int   n;
        n = 0;
        a_s_stb = 1'b1; a_s_we = we; a_s_addr = addr; a_s_data = data; a_s_sel = sel;
        if (push_m) a_mq.push_back(exp_m);
        if (push_s) a_sq.push_back(exp_s);
        do begin
            acc = !a_s_stall;
            step();
            n++;
        end while (!acc && n < 50);
        check("accept", acc, 1'b1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((a_mq.size() + a_sq.size() + b_mq.size() + b_sq.size()) != 0 && n < 60) begin
            step();
            n++;
        end
        check("drain", a_mq.size() + a_sq.size() + b_mq.size() + b_sq.size(), 0);
    endtask

    // Monitor: compares every master request and every slave ack with the queues.
    initial begin
        logic a_prev_ack, b_prev_ack;
        areq_t ea;
        breq_t eb;
        a_prev_ack = 1'b0;
        b_prev_ack = 1'b0;
        forever begin
            @(negedge i_clk);
            if (i_reset === 1'b0) begin
                if (a_m_stb && !a_m_stall) begin
                    check("a_req_expected", a_mq.size() > 0, 1'b1);
                    if (a_mq.size() > 0) begin
                        ea = a_mq.pop_front();
                        check("a_req", {a_m_we, a_m_addr, a_m_data, a_m_sel}, ea);
                    end
                end
                if (a_s_ack) begin
                    check("a_ack_expected", a_sq.size() > 0, 1'b1);
                    check("a_ack_latency", a_prev_ack, 1'b1);
                    if (a_sq.size() > 0) check("a_rdata", a_s_rdata, a_sq.pop_front());
                end
                if (b_m_stb && !b_m_stall) begin
                    check("b_req_expected", b_mq.size() > 0, 1'b1);
                    if (b_mq.size() > 0) begin
                        eb = b_mq.pop_front();
                        check("b_req", {b_m_we, b_m_addr, b_m_data, b_m_sel}, eb);
                    end
                end
                if (b_s_ack) begin
                    check("b_ack_expected", b_sq.size() > 0, 1'b1);
                    check("b_ack_latency", b_prev_ack, 1'b1);
                    if (b_sq.size() > 0) check("b_rdata", b_s_rdata, b_sq.pop_front());
                end
            end
            a_prev_ack = a_m_ack;
            b_prev_ack = b_m_ack;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset = 1'b1;
        a_s_cyc = 0; a_s_stb = 0; a_s_we = 0; a_s_addr = '0; a_s_data = '0; a_s_sel = '0;
        a_m_ack = 0; a_m_err = 0; a_m_stall = 0; a_m_rdata = MEM_A;
        b_s_cyc = 0; b_s_stb = 0; b_s_we = 0; b_s_addr = '0; b_s_data = '0; b_s_sel = '0;
        b_m_ack = 0; b_m_err = 0; b_m_stall = 0; b_m_rdata = MEM_B;
        ack_auto = 1'b0; ack_pipe = 2'b00; stall_cnt = 0;
        step(); step();
        i_reset = 1'b0;
        step();

        // Reset state
        check("rst_m_cyc", a_m_cyc, 1'b0);
        check("rst_m_stb", a_m_stb, 1'b0);
        check("rst_s_ack", a_s_ack, 1'b0);
        check("rst_s_err", a_s_err, 1'b0);
        check("rst_s_stall", a_s_stall, 1'b0);
        check("rst_b_m_cyc", b_m_cyc, 1'b0);

        // Single write to addr 6: lane 2 lands on bits [63:32], sel 0x00F0
        ack_auto = 1'b1;
        a_s_cyc = 1'b1;
        issue(1'b1, 30'h6, 32'hDEADBEEF, 4'hF,
              1'b1, mka(1'b1, 28'h1, 128'h00000000_00000000_DEADBEEF_00000000, 16'h00F0),
              1'b1, 32'h33333333);
        a_s_stb = 1'b0;
        check("wr_m_stb_next", a_m_stb, 1'b1);
        check("wr_m_cyc", a_m_cyc, 1'b1);
        check("wr_m_addr", a_m_addr, 28'h1);
        drain();

        // Four back-to-back reads, addresses 0..3
        issue(1'b0, 30'h0, 32'h0, 4'hF, 1'b1, mka(1'b0, 28'h0, '0, 16'hF000), 1'b1, 32'h11111111);
        issue(1'b0, 30'h1, 32'h0, 4'hF, 1'b1, mka(1'b0, 28'h0, '0, 16'h0F00), 1'b1, 32'h22222222);
        issue(1'b0, 30'h2, 32'h0, 4'hF, 1'b1, mka(1'b0, 28'h0, '0, 16'h00F0), 1'b1, 32'h33333333);
        issue(1'b0, 30'h3, 32'h0, 4'hF, 1'b1, mka(1'b0, 28'h0, '0, 16'h000F), 1'b1, 32'h44444444);
        a_s_stb = 1'b0;
        drain();

        // Master stall held 5 cycles across a 3-request burst
        a_m_stall = 1'b1; stall_cnt = 5;
        issue(1'b0, 30'h4, 32'h0, 4'hF, 1'b1, mka(1'b0, 28'h1, '0, 16'hF000), 1'b1, 32'h11111111);
        check("stall_after_1", a_s_stall, 1'b0);
        issue(1'b0, 30'h5, 32'h0, 4'hF, 1'b1, mka(1'b0, 28'h1, '0, 16'h0F00), 1'b1, 32'h22222222);
        check("stall_after_2", a_s_stall, 1'b1);
        issue(1'b0, 30'h6, 32'h0, 4'hF, 1'b1, mka(1'b0, 28'h1, '0, 16'h00F0), 1'b1, 32'h33333333);
        a_s_stb = 1'b0;
        drain();

        // FIFO full with acks withheld (depth 4)
        ack_auto = 1'b0; a_m_ack = 1'b0;
        issue(1'b0, 30'h8, 32'h0, 4'hF, 1'b1, mka(1'b0, 28'h2, '0, 16'hF000), 1'b1, 32'h11111111);
        issue(1'b0, 30'h9, 32'h0, 4'hF, 1'b1, mka(1'b0, 28'h2, '0, 16'h0F00), 1'b1, 32'h22222222);
        issue(1'b0, 30'hA, 32'h0, 4'hF, 1'b1, mka(1'b0, 28'h2, '0, 16'h00F0), 1'b1, 32'h33333333);
        check("full_before_4", a_s_stall, 1'b0);
        issue(1'b0, 30'hB, 32'h0, 4'hF, 1'b1, mka(1'b0, 28'h2, '0, 16'h000F), 1'b1, 32'h44444444);
        a_s_stb = 1'b0;
        check("full_after_4", a_s_stall, 1'b1);
        a_m_ack = 1'b1;
        step();
        a_m_ack = 1'b0;
        check("full_after_ack", a_s_stall, 1'b0);
        a_m_ack = 1'b1;
        step(); step(); step();
        a_m_ack = 1'b0;
        drain();

        // Bus error with 3 reads outstanding
        issue(1'b0, 30'h0, 32'h0, 4'hF, 1'b1, mka(1'b0, 28'h0, '0, 16'hF000), 1'b0, '0);
        issue(1'b0, 30'h1, 32'h0, 4'hF, 1'b1, mka(1'b0, 28'h0, '0, 16'h0F00), 1'b0, '0);
        issue(1'b0, 30'h2, 32'h0, 4'hF, 1'b1, mka(1'b0, 28'h0, '0, 16'h00F0), 1'b0, '0);
        a_s_stb = 1'b0;
        step(); step(); step();
        check("err_pre_cyc", a_m_cyc, 1'b1);
        a_m_err = 1'b1;
        step();
        a_m_err = 1'b0;
        check("err_s_err", a_s_err, 1'b1);
        check("err_m_cyc", a_m_cyc, 1'b0);
        check("err_m_stb", a_m_stb, 1'b0);
        a_m_ack = 1'b1;
        step();
        a_m_ack = 1'b0;
        check("err_pulse_1", a_s_err, 1'b0);
        step();
        check("err_stray_ack", a_s_ack, 1'b0);
        // FIFO must be empty: exactly four more fit before stalling
        issue(1'b0, 30'hC, 32'h0, 4'hF, 1'b1, mka(1'b0, 28'h3, '0, 16'hF000), 1'b1, 32'h11111111);
        issue(1'b0, 30'hD, 32'h0, 4'hF, 1'b1, mka(1'b0, 28'h3, '0, 16'h0F00), 1'b1, 32'h22222222);
        issue(1'b0, 30'hE, 32'h0, 4'hF, 1'b1, mka(1'b0, 28'h3, '0, 16'h00F0), 1'b1, 32'h33333333);
        check("err_fifo_empty_3", a_s_stall, 1'b0);
        issue(1'b0, 30'hF, 32'h0, 4'hF, 1'b1, mka(1'b0, 28'h3, '0, 16'h000F), 1'b1, 32'h44444444);
        a_s_stb = 1'b0;
        check("err_fifo_full_4", a_s_stall, 1'b1);
        a_m_ack = 1'b1;
        step(); step(); step(); step();
        a_m_ack = 1'b0;
        drain();

        // Reset in the middle of a stalled burst
        stall_cnt = 100; a_m_stall = 1'b1;
        issue(1'b0, 30'h0, 32'h0, 4'hF, 1'b0, '0, 1'b0, '0);
        issue(1'b0, 30'h1, 32'h0, 4'hF, 1'b0, '0, 1'b0, '0);
        check("rst2_pre_stall", a_s_stall, 1'b1);
        i_reset = 1'b1; a_s_cyc = 1'b0; a_s_stb = 1'b0;
        step();
        check("rst2_m_cyc", a_m_cyc, 1'b0);
        check("rst2_m_stb", a_m_stb, 1'b0);
        check("rst2_s_ack", a_s_ack, 1'b0);
        check("rst2_s_err", a_s_err, 1'b0);
        check("rst2_s_stall", a_s_stall, 1'b0);
        i_reset = 1'b0; stall_cnt = 0; a_m_stall = 1'b0;
        step(); step();
        check("rst2_idle_stb", a_m_stb, 1'b0);

        // Ratio 2 (DUT B): addr 5 -> master addr 2, lane 1 at bits [31:0]
        b_s_cyc = 1'b1;
        b_s_stb = 1'b1; b_s_we = 1'b1; b_s_addr = 30'h5; b_s_data = 32'hCAFEF00D; b_s_sel = 4'hF;
        b_mq.push_back(mkb(1'b1, 29'h2, 64'h00000000_CAFEF00D, 8'h0F));
        b_sq.push_back(32'h12345678);
        step();
        b_s_stb = 1'b0;
        check("b_m_addr", b_m_addr, 29'h2);
        b_m_ack = 1'b1;
        step();
        b_m_ack = 1'b0;
        b_s_stb = 1'b1; b_s_we = 1'b0; b_s_addr = 30'h4; b_s_data = 32'h0;
        b_mq.push_back(mkb(1'b0, 29'h2, 64'h0, 8'hF0));
        b_sq.push_back(32'hAAAA5555);
        step();
        b_s_stb = 1'b0;
        b_m_ack = 1'b1;
        step();
        b_m_ack = 1'b0;
        drain();
        b_s_cyc = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
